// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, loads IR, pulses PCWre.
// Optional watchdog on outstanding fetches is enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_unit #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] currentPC,
  input  logic        fetch_req,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic        PCWre,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("ifetch_unit: TIMEOUT must be within 2..255");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DRAIN, S_DONE, S_FAULT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_ir, w_ir_nxt;
  logic        r_irv, w_irv_nxt;
  logic        r_pcwre, w_pcwre_nxt;
  logic        r_fault, w_fault_nxt;
  logic [1:0]  r_cause, w_cause_nxt;

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        w_tmo;
  // Counter is 0 in the first cycle of WAIT/DRAIN, so TIMEOUT-1 marks the last allowed cycle.
  assign w_tmo = (r_cnt == 8'(TIMEOUT - 1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_req_nxt   = r_req;
    w_ir_nxt    = r_ir;
    w_irv_nxt   = r_irv;
    w_pcwre_nxt = 1'b0;
    w_fault_nxt = r_fault;
    w_cause_nxt = r_cause;
`ifdef IFETCH_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_irv_nxt = 1'b0;
        end else if (fetch_req) begin
          if (currentPC[1:0] == 2'b00) begin
            w_addr_nxt  = currentPC;
            w_req_nxt   = 1'b1;
            w_irv_nxt   = 1'b0;
            w_state_nxt = S_WAIT;
`ifdef IFETCH_TIMEOUT_EN
            w_cnt_nxt   = 8'd0;
`endif
          end else begin
            w_fault_nxt = 1'b1;
            w_cause_nxt = 2'b01;
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_req_nxt = 1'b0;
          if (flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_ir_nxt    = mem_rdata;
            w_irv_nxt   = 1'b1;
            w_pcwre_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (flush) begin
          // The bus transaction cannot be aborted; swallow its response in DRAIN.
          w_state_nxt = S_DRAIN;
`ifdef IFETCH_TIMEOUT_EN
          w_cnt_nxt   = 8'd0;
        end else if (w_tmo) begin
          w_req_nxt   = 1'b0;
          w_fault_nxt = 1'b1;
          w_cause_nxt = 2'b10;
          w_state_nxt = S_FAULT;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
`endif
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
`ifdef IFETCH_TIMEOUT_EN
        end else if (w_tmo) begin
          w_req_nxt   = 1'b0;
          w_fault_nxt = 1'b1;
          w_cause_nxt = 2'b10;
          w_state_nxt = S_FAULT;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
`endif
        end
      end
      S_DONE: begin
        if (flush) w_irv_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (flush) begin
          w_fault_nxt = 1'b0;
          w_cause_nxt = 2'b00;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_addr  <= 32'h0;
      r_req   <= 1'b0;
      r_ir    <= IR_RESET;
      r_irv   <= 1'b0;
      r_pcwre <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= 2'b00;
`ifdef IFETCH_TIMEOUT_EN
      r_cnt   <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_ir    <= w_ir_nxt;
      r_irv   <= w_irv_nxt;
      r_pcwre <= w_pcwre_nxt;
      r_fault <= w_fault_nxt;
      r_cause <= w_cause_nxt;
`ifdef IFETCH_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign mem_addr    = r_addr;
  assign mem_req     = r_req;
  assign IR          = r_ir;
  assign ir_valid    = r_irv;
  assign PCWre       = r_pcwre;
  assign fault       = r_fault;
  assign fault_cause = r_cause;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected IR words are queued at ack time
// and checked whenever PCWre pulses; direct checks cover control outputs.
module tb_ifetch_unit;
  localparam logic [31:0] IRR = 32'hCAFE_F00D;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] currentPC;
  logic        fetch_req, flush, mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, IR;
  logic        mem_req, ir_valid, PCWre, fault;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic        prev_pcwre = 1'b0;

  ifetch_unit #(.TIMEOUT(4), .IR_RESET(IRR)) dut (
    .CLK(CLK), .Reset(Reset), .currentPC(currentPC), .fetch_req(fetch_req),
    .flush(flush), .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .IR(IR), .ir_valid(ir_valid), .PCWre(PCWre),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Output side of the scoreboard: every PCWre pulse must match a queued word.
  always @(negedge CLK) begin
    if (PCWre === 1'b1) begin
      chk("pcwre_one_cycle", {31'b0, prev_pcwre}, 32'd0);
      if (sb_q.size() == 0) chk("pcwre_unexpected", 32'd1, 32'd0);
      else chk("sb_ir", IR, sb_q.pop_front());
      chk("sb_ir_valid", {31'b0, ir_valid}, 32'd1);
    end
    prev_pcwre = (PCWre === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hold;
    Reset = 1'b1; currentPC = '0; fetch_req = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_ir", IR, IRR);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_ctl", {28'b0, ir_valid, PCWre, fault, |fault_cause}, 32'd0);
    tick; Reset = 1'b0;

    // normal fetch, ack on the third WAIT cycle
    currentPC = 32'h10; fetch_req = 1'b1;
    tick; fetch_req = 1'b0;
    chk("n_req", {31'b0, mem_req}, 32'd1);
    chk("n_addr", mem_addr, 32'h10);
    chk("n_irv0", {31'b0, ir_valid}, 32'd0);
    tick; chk("n_hold_req", {31'b0, mem_req}, 32'd1);
    tick; chk("n_hold_addr", mem_addr, 32'h10);
    sb_q.push_back(32'h2001_0005); mem_ack = 1'b1; mem_rdata = 32'h2001_0005;
    tick; mem_ack = 1'b0; mem_rdata = '0;
    chk("n_ir", IR, 32'h2001_0005);
    chk("n_pcwre", {31'b0, PCWre}, 32'd1);
    chk("n_req_drop", {31'b0, mem_req}, 32'd0);
    tick;
    chk("n_pcwre_end", {31'b0, PCWre}, 32'd0);
    chk("n_irv_hold", {31'b0, ir_valid}, 32'd1);

    // misaligned fetch, fetch_req ignored in FAULT, flush clears
    currentPC = 32'h6; fetch_req = 1'b1;
    tick;
    chk("m_req", {31'b0, mem_req}, 32'd0);
    chk("m_fault", {29'b0, fault, fault_cause}, 32'b101);
    tick;
    chk("m_sticky", {29'b0, fault, fault_cause}, 32'b101);
    chk("m_req_ign", {31'b0, mem_req}, 32'd0);
    fetch_req = 1'b0; flush = 1'b1;
    tick; flush = 1'b0;
    chk("m_clear", {29'b0, fault, fault_cause}, 32'd0);

    // flush in flight, late ack drained
    currentPC = 32'h20; fetch_req = 1'b1;
    tick; fetch_req = 1'b0; flush = 1'b1;
    tick; flush = 1'b0;
    chk("f_drain_req", {31'b0, mem_req}, 32'd1);
    chk("f_drain_addr", mem_addr, 32'h20);
    tick;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick; mem_ack = 1'b0;
    chk("f_ir_keep", IR, 32'h2001_0005);
    chk("f_ctl", {29'b0, ir_valid, PCWre, mem_req}, 32'd0);

    // same-cycle flush and ack, then IDLE accepts next fetch immediately
    currentPC = 32'h30; fetch_req = 1'b1;
    tick; fetch_req = 1'b0;
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick; flush = 1'b0; mem_ack = 1'b0;
    chk("s_ir_keep", IR, 32'h2001_0005);
    chk("s_ctl", {30'b0, PCWre, mem_req}, 32'd0);
    currentPC = 32'h34; fetch_req = 1'b1;
    tick; fetch_req = 1'b0;
    chk("s_idle_req", {31'b0, mem_req}, 32'd1);
    sb_q.push_back(32'h3333_4444); mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    tick; mem_ack = 1'b0;
    chk("d_pcwre", {31'b0, PCWre}, 32'd1);
    flush = 1'b1;  // flush while in DONE
    tick; flush = 1'b0;
    chk("d_flush_irv", {31'b0, ir_valid}, 32'd0);
    chk("d_flush_pcwre", {31'b0, PCWre}, 32'd0);

    // flush beats fetch_req in IDLE
    currentPC = 32'h50; fetch_req = 1'b1;
    tick; fetch_req = 1'b0;
    sb_q.push_back(32'h5050_5050); mem_ack = 1'b1; mem_rdata = 32'h5050_5050;
    tick; mem_ack = 1'b0;
    tick;
    chk("p_irv", {31'b0, ir_valid}, 32'd1);
    currentPC = 32'h60; fetch_req = 1'b1; flush = 1'b1;
    tick; fetch_req = 1'b0; flush = 1'b0;
    chk("p_no_req", {31'b0, mem_req}, 32'd0);
    chk("p_irv_clr", {31'b0, ir_valid}, 32'd0);

    // timeout behaviour
    currentPC = 32'h40; fetch_req = 1'b1;
    tick; fetch_req = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    hold = 1;
    repeat (3) begin
      tick;
      if (mem_req) hold++;
    end
    chk("t_hold", hold, 32'd4);
    tick;
    chk("t_req_drop", {31'b0, mem_req}, 32'd0);
    chk("t_fault", {29'b0, fault, fault_cause}, 32'b110);
    flush = 1'b1;
    tick; flush = 1'b0;
    chk("t_clear", {29'b0, fault, fault_cause}, 32'd0);
`else
    hold = 0;
    repeat (100) begin
      tick;
      if (mem_req) hold++;
    end
    chk("t_hold", hold, 32'd100);
    chk("t_no_fault", {29'b0, fault, fault_cause}, 32'd0);
    sb_q.push_back(32'h4040_4040); mem_ack = 1'b1; mem_rdata = 32'h4040_4040;
    tick; mem_ack = 1'b0;
    tick;
`endif

    // async reset mid-WAIT, stray ack afterwards ignored
    currentPC = 32'h70; fetch_req = 1'b1;
    tick; fetch_req = 1'b0;
    chk("r_req_pre", {31'b0, mem_req}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("r_async_req", {31'b0, mem_req}, 32'd0);
    chk("r_async_ir", IR, IRR);
    chk("r_async_addr", mem_addr, 32'd0);
    #2 Reset = 1'b0;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick; mem_ack = 1'b0;
    chk("r_stray_ir", IR, IRR);
    chk("r_stray_ctl", {29'b0, ir_valid, PCWre, mem_req}, 32'd0);
    tick;

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the number of cycles without mem_ack before a timeout fault (valid range 2..255).
REQ-002 SHALL have parameter IR_RESET, default 32'h0000_0000, meaning the reset value of IR.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port currentPC, input, 32 bits: the word address to fetch, driven by the PC block.
REQ-006 SHALL have port fetch_req, input, 1 bit: the core requests the instruction at currentPC.
REQ-007 SHALL have port flush, input, 1 bit: a redirect that discards any in-flight fetch result and clears a fault.
REQ-008 SHALL have port mem_addr, output, 32 bits: the instruction memory word address.
REQ-009 SHALL have port mem_req, output, 1 bit: the memory request, held until acknowledged.
REQ-010 SHALL have port mem_ack, input, 1 bit: the memory response strobe, valid for one cycle.
REQ-011 SHALL have port mem_rdata, input, 32 bits: the instruction word, valid only while mem_ack=1.
REQ-012 SHALL have port IR, output, 32 bits: the instruction register.
REQ-013 SHALL have port ir_valid, output, 1 bit: IR holds an undiscarded fetched instruction.
REQ-014 SHALL have port PCWre, output, 1 bit: a one-cycle pulse that permits the PC to advance.
REQ-015 SHALL have port fault, output, 1 bit: a sticky fetch fault.
REQ-016 SHALL have port fault_cause, output, 2 bits: 01 = misaligned, 10 = timeout, 00 = none.

Function
REQ-017 SHALL implement the states IDLE, WAIT, DRAIN, DONE and FAULT, all registered.
REQ-018 SHALL, in IDLE with fetch_req=1, flush=0 and currentPC[1:0]=00, register mem_addr<=currentPC and mem_req<=1, clear ir_valid, and go to WAIT.
REQ-019 SHALL, in IDLE with fetch_req=1, flush=0 and currentPC[1:0]!=00, go to FAULT with fault=1 and fault_cause=01, and SHALL NOT assert mem_req.
REQ-020 SHALL, in WAIT, hold mem_req=1 and a stable mem_addr until mem_ack is sampled high.
REQ-021 SHALL, on mem_ack in WAIT, load IR<=mem_rdata, set ir_valid=1, set PCWre=1, clear mem_req and go to DONE, with all of these visible right after that edge (one-edge latency from ack).
REQ-022 SHALL keep DONE for exactly one cycle with PCWre=1, then return to IDLE with PCWre=0.
REQ-023 SHALL, when flush=1 in WAIT, go to DRAIN and keep mem_req asserted, because an issued memory transaction is never aborted.
REQ-024 SHALL, on mem_ack in DRAIN, leave IR unchanged, keep ir_valid=0 and PCWre=0, clear mem_req, and go to IDLE.
REQ-025 SHALL treat flush and mem_ack in the same WAIT cycle as a discard: IR unchanged, no PCWre, go to IDLE.
REQ-026 SHALL, on flush in IDLE or DONE, clear ir_valid; a flush in DONE SHALL NOT suppress the PCWre pulse already registered.
REQ-027 SHALL ignore fetch_req in FAULT.
REQ-028 SHALL, on flush in FAULT, clear fault and fault_cause and go to IDLE.
REQ-029 SHALL ignore mem_ack whenever mem_req=0.
REQ-030 SHALL give flush priority over fetch_req in IDLE, so that no request is issued that cycle.

Reset
REQ-031 SHALL, while Reset=1 and regardless of CLK, force state=IDLE, IR=IR_RESET, ir_valid=0, PCWre=0, mem_req=0, mem_addr=0, fault=0, fault_cause=00, and the timeout counter to 0.
REQ-032 SHALL treat Reset asserted mid-transaction as abandoning the transaction, and SHALL ignore a mem_ack arriving after reset deasserts.

Configuration
REQ-033 SHALL, with IFETCH_TIMEOUT_EN defined, count cycles spent in WAIT or DRAIN; the counter clears on entry to either state.
REQ-034 SHALL, with IFETCH_TIMEOUT_EN defined, treat TIMEOUT consecutive cycles without mem_ack as a timeout: drop mem_req and go to FAULT with fault_cause=10, whether in WAIT or DRAIN.
REQ-035 SHALL, without IFETCH_TIMEOUT_EN, omit the counter, wait for mem_ack indefinitely, and never produce fault_cause=10.

Verification
REQ-036 Normal fetch: currentPC=0x0000_0010, fetch_req=1, mem_ack after 3 cycles with rdata=0x2001_0005 -> mem_addr=0x10; IR=0x2001_0005; ir_valid=1; PCWre high exactly 1 cycle.
REQ-037 Misaligned fetch: currentPC=0x0000_0006, fetch_req=1 -> no mem_req; fault=1, fault_cause=01 next cycle; then flush=1 -> fault=0, state IDLE.
REQ-038 Flush in flight: fetch 0x20, flush=1 in WAIT, ack 2 cycles later with rdata=0xDEAD_BEEF -> IR keeps its prior value; PCWre never pulses; back to IDLE.
REQ-039 Same-cycle flush and ack in WAIT -> IR unchanged, PCWre=0, IDLE the next cycle.
REQ-040 Timeout (macro defined, TIMEOUT=4): fetch 0x40, no ack -> mem_req drops and fault_cause=10 after 4 WAIT cycles; with the macro undefined, mem_req stays high for 100 cycles.
REQ-041 Async reset: Reset=1 pulsed mid-WAIT between clock edges -> mem_req=0 and IR=IR_RESET immediately; a later stray mem_ack is ignored.
